// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with slave split parking and a hold timeout.
// The grant is registered, and every handover goes through a one-cycle
// TURN state, so the bus is idle for at least one cycle between owners.
module bus_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [N_MASTERS-1:0]                             m_req,
  input  logic                                             split,
  input  logic [N_MASTERS-1:0]                             split_done,
  output logic [N_MASTERS-1:0]                             m_grant,
  output logic [(N_MASTERS > 1 ? $clog2(N_MASTERS) : 1)-1:0] bus_owner,
  output logic                                             bus_valid,
  output logic [N_MASTERS-1:0]                             split_mask,
  output logic                                             timeout_pulse
);

  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t              state;
  logic [OW-1:0]       rr_ptr;
  logic [CW-1:0]       hold_cnt;

  logic [N_MASTERS-1:0] eligible;
  logic                 sel_found;
  logic [OW-1:0]        sel_idx;
  logic [N_MASTERS-1:0] sel_onehot;
  logic [N_MASTERS-1:0] split_set;
  logic [OW-1:0]        next_ptr;
  logic                 owner_req;
  logic                 hold_expired;
  int                   probe;

  assign eligible     = m_req & ~split_mask;
  assign owner_req    = m_req[bus_owner];
  assign hold_expired = (hold_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign next_ptr     = OW'((int'(bus_owner) + 1) % N_MASTERS);

  // Pick the first eligible master searching upward from rr_ptr with wrap;
  // the loop runs from the farthest offset down so the nearest one wins.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    probe      = 0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      probe = (int'(rr_ptr) + i) % N_MASTERS;
      if (eligible[probe]) begin
        sel_found = 1'b1;
        sel_idx   = OW'(probe);
      end
    end
    sel_onehot = '0;
    sel_onehot[sel_idx] = sel_found;
  end

  // The owner gets parked when a split is seen while the grant is held.
  always_comb begin
    split_set = '0;
    if (state == GRANT && split) begin
      split_set[bus_owner] = 1'b1;
    end
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
      m_grant       <= '0;
      bus_owner     <= '0;
      bus_valid     <= 1'b0;
      split_mask    <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      // A set from split wins over a simultaneous clear from split_done.
      split_mask    <= (split_mask & ~split_done) | split_set;
      case (state)
        IDLE, TURN: begin
          if (sel_found) begin
            m_grant   <= sel_onehot;
            bus_owner <= sel_idx;
            bus_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end else begin
            state     <= IDLE;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (split || !owner_req || hold_expired) begin
            m_grant       <= '0;
            bus_owner     <= '0;
            bus_valid     <= 1'b0;
            rr_ptr        <= next_ptr;
            state         <= TURN;
            // Only a forced revoke pulses; split and release take priority.
            timeout_pulse <= !split && owner_req && hold_expired;
          end
        end
        default: begin
          m_grant   <= '0;
          bus_owner <= '0;
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters and an 8-cycle timeout.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_bus_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] m_req;
  logic         split;
  logic [N-1:0] split_done;
  logic [N-1:0] m_grant;
  logic [0:0]   bus_owner;
  logic         bus_valid;
  logic [N-1:0] split_mask;
  logic         timeout_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_req         (m_req),
    .split         (split),
    .split_done    (split_done),
    .m_grant       (m_grant),
    .bus_owner     (bus_owner),
    .bus_valid     (bus_valid),
    .split_mask    (split_mask),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; m_req = '0; split = 1'b0; split_done = '0;

    // Reset then idle
    tick(); tick();
    chk("rst_grant", 32'(m_grant), 32'h0);
    chk("rst_owner", 32'(bus_owner), 32'h0);
    chk("rst_valid", 32'(bus_valid), 32'h0);
    chk("rst_mask", 32'(split_mask), 32'h0);
    chk("rst_pulse", 32'(timeout_pulse), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_grant", 32'(m_grant), 32'h0);
      chk("idle_valid", 32'(bus_valid), 32'h0);
      chk("idle_mask", 32'(split_mask), 32'h0);
    end

    // Single request: granted one edge after sampling, held 5 cycles
    m_req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("single_grant", 32'(m_grant), 32'h1);
      chk("single_owner", 32'(bus_owner), 32'h0);
      chk("single_valid", 32'(bus_valid), 32'h1);
    end
    m_req = 2'b00;
    tick();
    chk("single_drop", 32'(m_grant), 32'h0);
    chk("single_drop_pulse", 32'(timeout_pulse), 32'h0);
    tick();
    chk("single_idle", 32'(m_grant), 32'h0);

    // Round robin: pointer now at 1, so master 1 goes first
    m_req = 2'b11;
    tick(); chk("rr_g1a", 32'(m_grant), 32'h2);
    chk("rr_owner1", 32'(bus_owner), 32'h1);
    tick(); chk("rr_g1b", 32'(m_grant), 32'h2);
    tick(); chk("rr_g1c", 32'(m_grant), 32'h2);
    m_req = 2'b01;
    tick(); chk("rr_dead1", 32'(m_grant), 32'h0);
    m_req = 2'b11;
    tick(); chk("rr_g0a", 32'(m_grant), 32'h1);
    tick(); chk("rr_g0b", 32'(m_grant), 32'h1);
    tick(); chk("rr_g0c", 32'(m_grant), 32'h1);
    m_req = 2'b10;
    tick(); chk("rr_dead2", 32'(m_grant), 32'h0);
    m_req = 2'b11;
    tick(); chk("rr_g1again", 32'(m_grant), 32'h2);
    m_req = 2'b00;
    tick(); chk("rr_release", 32'(m_grant), 32'h0);
    tick();

    // Split: master 0 parked, master 1 served, master 0 back after split_done
    m_req = 2'b11;
    tick(); chk("sp_g0", 32'(m_grant), 32'h1);
    split = 1'b1;
    tick(); chk("sp_drop", 32'(m_grant), 32'h0);
    chk("sp_mask_set", 32'(split_mask), 32'h1);
    split = 1'b0;
    tick(); chk("sp_g1", 32'(m_grant), 32'h2);
    tick(); chk("sp_g1_hold", 32'(m_grant), 32'h2);
    tick(); chk("sp_mask_hold", 32'(split_mask), 32'h1);
    split_done = 2'b01;
    tick(); chk("sp_mask_clr", 32'(split_mask), 32'h0);
    chk("sp_g1_still", 32'(m_grant), 32'h2);
    split_done = 2'b00;
    m_req = 2'b01;
    tick(); chk("sp_turn", 32'(m_grant), 32'h0);
    tick(); chk("sp_g0_back", 32'(m_grant), 32'h1);

    // Split and split_done on the same index in one cycle: set wins
    split = 1'b1; split_done = 2'b01;
    tick(); chk("sw_mask", 32'(split_mask), 32'h1);
    chk("sw_drop", 32'(m_grant), 32'h0);
    split = 1'b0;
    tick(); chk("sw_parked", 32'(m_grant), 32'h0);
    chk("sw_mask_clr", 32'(split_mask), 32'h0);
    split_done = 2'b00;
    tick(); chk("sw_regrant", 32'(m_grant), 32'h1);
    m_req = 2'b00;
    tick(); chk("sw_release", 32'(m_grant), 32'h0);
    tick();

    // Timeout with a single permanent requester
    m_req = 2'b01;
    for (int i = 0; i < TO; i++) begin
      tick();
      chk("to_hold", 32'(m_grant), 32'h1);
      chk("to_nopulse", 32'(timeout_pulse), 32'h0);
    end
    tick();
    chk("to_revoke", 32'(m_grant), 32'h0);
    chk("to_pulse", 32'(timeout_pulse), 32'h1);
    tick();
    chk("to_regrant", 32'(m_grant), 32'h1);
    chk("to_pulse_end", 32'(timeout_pulse), 32'h0);

    // Timeout with both requesting: master 1 takes over
    m_req = 2'b11;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to2_hold", 32'(m_grant), 32'h1);
    end
    tick();
    chk("to2_revoke", 32'(m_grant), 32'h0);
    chk("to2_pulse", 32'(timeout_pulse), 32'h1);
    tick();
    chk("to2_g1", 32'(m_grant), 32'h2);
    chk("to2_owner", 32'(bus_owner), 32'h1);

    // Asynchronous reset between edges while master 1 holds the bus
    #2 reset = 1'b1;
    #1;
    chk("arst_grant", 32'(m_grant), 32'h0);
    chk("arst_mask", 32'(split_mask), 32'h0);
    chk("arst_valid", 32'(bus_valid), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("arst_first", 32'(m_grant), 32'h1);
    chk("arst_owner", 32'(bus_owner), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that grants ownership of the shared system bus to one master at a time.
- Instantiated inside system_bus, directly downstream of the top-level clk/reset: it consumes master requests and drives the one-hot grant that steers the bus multiplexers.
- Supports slave-initiated split: a split master is parked until the slave signals completion.
- Enforces a hold timeout so no master can starve the others.

Parameters:
- N_MASTERS, 2, number of masters; legal range 1..4.
- TIMEOUT_CYCLES, 256, maximum consecutive cycles one master may hold a grant; must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset (1 = in reset).
- m_req  in  N_MASTERS  per-master request; held high for the whole transaction.
- split  in  1  slave splits the current owner's transaction; sampled only in GRANT.
- split_done  in  N_MASTERS  slave ready to resume the parked master i.
- m_grant  out  N_MASTERS  registered one-hot grant, or all zero.
- bus_owner  out  max(1,clog2(N_MASTERS))  index of the current owner; 0 when bus_valid=0.
- bus_valid  out  1  high when m_grant is non-zero.
- split_mask  out  N_MASTERS  status: masters currently parked by split.
- timeout_pulse  out  1  one-cycle pulse on a forced revoke.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-transaction):
  - m_grant=0, bus_owner=0, bus_valid=0, split_mask=0, timeout_pulse=0.
  - state=IDLE, rr_ptr=0, hold counter=0.
- Eligibility: eligible = m_req & ~split_mask.
- Selection: the first eligible index found searching upward from rr_ptr, wrapping at N_MASTERS-1 back to 0.
- States:
  - IDLE: if eligible is non-zero, register the grant for the selected master at the next edge, clear the counter, go to GRANT. Otherwise stay in IDLE. Request-to-grant latency is 1 cycle.
  - GRANT: the counter increments each cycle. Exits are checked in priority order:
    1. split=1: set split_mask[owner], drop the grant at the next edge, go to TURN.
    2. m_req[owner]=0: drop the grant, go to TURN.
    3. counter==TIMEOUT_CYCLES-1 with m_req[owner] still high: drop the grant, pulse timeout_pulse in the cycle the grant is low, go to TURN.
    4. Otherwise hold the grant.
    - On every exit, rr_ptr <= (owner+1) mod N_MASTERS.
  - TURN: exactly one dead cycle with grant=0. Arbitration runs with the same rule as IDLE: if something is eligible, the grant is registered at the next edge and the FSM goes to GRANT; otherwise it goes to IDLE.
- Between owners there is always at least one grant-free cycle, with no exceptions.
- split_done[i] clears split_mask[i] at the next edge. If the set from split and split_done target the same index in the same cycle, the set wins.
- split_done for a non-parked master is ignored.
- A timed-out master with its request still high stays eligible. It is served again only after the round-robin pointer wraps back to it.
- split and req-drop in the same GRANT cycle: treated as split (the mask is set).
- A requester that drops m_req before being granted is never granted. Arbitration uses only the m_req value sampled at that edge.
- N_MASTERS=1: rr_ptr remains 0; split and timeout behave the same as for N>1.
- Counter width is clog2(TIMEOUT_CYCLES+1). It never wraps because the revoke happens first.
- Outputs are driven only from flops; there is no combinational path from any input to any output.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then release with m_req=00.
  - Required: m_grant=00, bus_valid=0, split_mask=00 on every cycle for 10 cycles.
- Single request:
  - Stimulus: m_req=01 sampled at edge k, held for 5 cycles, then dropped.
  - Required: m_grant=01 from k+1; grant drops one edge after m_req[0]=0 is sampled; bus_owner=0 throughout.
- Round-robin fairness:
  - Stimulus: m_req=11 held continuously; each master drops its request for 1 cycle after 3 granted cycles, then re-requests.
  - Required: grants alternate 01, 00, 10, 00, 01; exactly one dead cycle between owners.
- Split:
  - Stimulus: master 0 granted; split=1 for one cycle while m_req=11.
  - Required: split_mask=01, master 1 granted after one dead cycle, master 0 never granted until split_done=01.
  - Then: after split_done, master 0 is granted when master 1 releases.
- Timeout (TIMEOUT_CYCLES=8):
  - Stimulus: m_req=01 held permanently.
  - Required: grant high for exactly 8 cycles, then one TURN cycle with timeout_pulse=1, then master 0 is re-granted.
  - Also: with m_req=11, master 1 is granted after the timeout.
- Reset mid-grant:
  - Stimulus: assert reset asynchronously between edges while m_grant=10.
  - Required: m_grant=00 and split_mask=00 immediately, before the next clk edge.
  - Then: after release, the first grant goes to master 0 (rr_ptr=0).
